frame_sequencer: RTL and testbench

- Sequences the depth-tested draw pipeline once per frame: clear, draw, drain, swap.
- Clear: sweeps every framebuffer/depth address, writing clear colour and far depth with drawing=0.
- Draw: admits rasterizer fragments with drawing=1 and depth read enabled. A 4-deep address scoreboard stalls same-address fragments, closing the depth-writer read-after-write hazard.
- Swap: toggles the buffer select on vsync. Sits between the rasterizer and the depth-writer input.

---
 rtl/frame_sequencer.sv | 157 +++++++++++++++
 tb/tb_frame_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Per-frame clear/draw/drain/swap sequencer between rasterizer and depth writer; outputs registered, 1 cycle from issue.
// Backpressure: raster_ready_out drops for same-address fragments still inside the PIPE_LAT-deep depth-writer window.
module frame_sequencer #(
  parameter int FB_BIT_WIDTH    = 16,
  parameter int DEPTH_BIT_WIDTH = 16,
  parameter int FB_ADDR_WIDTH   = 17,
  parameter int FB_SIZE         = 76800,
  parameter logic [FB_BIT_WIDTH-1:0]    CLEAR_COLOR = '0,
  parameter logic [DEPTH_BIT_WIDTH-1:0] CLEAR_DEPTH = '1,
  parameter int PIPE_LAT        = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       frame_start_in,
  input  logic                       vsync_in,
  input  logic                       raster_valid_in,
  output logic                       raster_ready_out,
  input  logic [FB_ADDR_WIDTH-1:0]   raster_addr_in,
  input  logic [FB_BIT_WIDTH-1:0]    raster_color_in,
  input  logic [DEPTH_BIT_WIDTH-1:0] raster_depth_in,
  input  logic                       raster_done_in,
  output logic                       drawing_out,
  output logic                       fb_we_out,
  output logic                       dp_we_out,
  output logic                       dp_re_out,
  output logic                       fb_front_out,
  output logic [FB_ADDR_WIDTH-1:0]   fb_write_out,
  output logic [FB_ADDR_WIDTH-1:0]   dp_write_out,
  output logic [FB_BIT_WIDTH-1:0]    fb_value_out,
  output logic [DEPTH_BIT_WIDTH-1:0] dp_value_out,
  output logic                       busy_out,
  output logic                       frame_done_out
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_DRAIN_C, S_DRAW, S_DRAIN_D, S_SWAP} state_t;

  localparam logic [FB_ADDR_WIDTH-1:0] CLEAR_LAST = FB_ADDR_WIDTH'(FB_SIZE - 1);
  localparam logic [FB_ADDR_WIDTH-1:0] DRAIN_LAST = FB_ADDR_WIDTH'(PIPE_LAT - 1);
  localparam logic [FB_ADDR_WIDTH-1:0] CNT_ONE    = FB_ADDR_WIDTH'(1);

  state_t                     state, state_nxt;
  logic [FB_ADDR_WIDTH-1:0]   cnt;
  logic                       sb_vld  [PIPE_LAT];
  logic [FB_ADDR_WIDTH-1:0]   sb_addr [PIPE_LAT];
  logic                       hazard, accept, swap;
  logic                       iss_we, iss_re, iss_drawing;
  logic [FB_ADDR_WIDTH-1:0]   iss_addr;
  logic [FB_BIT_WIDTH-1:0]    iss_fb;
  logic [DEPTH_BIT_WIDTH-1:0] iss_dp;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // One counter serves the clear sweep and both drains; it restarts on every state change.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      cnt <= '0;
    else if (state_nxt != state)
      cnt <= '0;
    else if (state == S_CLEAR || state == S_DRAIN_C || state == S_DRAIN_D)
      cnt <= cnt + CNT_ONE;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (frame_start_in)     state_nxt = S_CLEAR;
      S_CLEAR:   if (cnt == CLEAR_LAST)  state_nxt = S_DRAIN_C;
      S_DRAIN_C: if (cnt == DRAIN_LAST)  state_nxt = S_DRAW;
      S_DRAW:    if (raster_done_in)     state_nxt = S_DRAIN_D;
      S_DRAIN_D: if (cnt == DRAIN_LAST)  state_nxt = S_SWAP;
      S_SWAP:    if (vsync_in)           state_nxt = S_IDLE;
      default:                           state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++)
      if (sb_vld[i] && sb_addr[i] == raster_addr_in) hazard = 1'b1;
    hazard = hazard && raster_valid_in;
  end

  always_comb begin
    raster_ready_out = (state == S_DRAW) && !hazard;
    accept           = raster_ready_out && raster_valid_in;
    busy_out         = (state != S_IDLE);
    swap             = (state == S_SWAP) && vsync_in;
    iss_we           = 1'b0;
    iss_re           = 1'b0;
    iss_drawing      = (state == S_DRAW) || (state == S_DRAIN_D);
    iss_addr         = raster_addr_in;
    iss_fb           = raster_color_in;
    iss_dp           = raster_depth_in;
    case (state)
      S_CLEAR: begin
        iss_we   = 1'b1;
        iss_addr = cnt;
        iss_fb   = CLEAR_COLOR;
        iss_dp   = CLEAR_DEPTH;
      end
      S_DRAW: begin
        iss_we = accept;
        iss_re = accept;
      end
      default: ;
    endcase
  end

  // Bubbles shift in when nothing is accepted, so a stalled fragment frees up after at most PIPE_LAT cycles.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        sb_vld[i]  <= 1'b0;
        sb_addr[i] <= '0;
      end
    end else begin
      sb_vld[0]  <= accept;
      sb_addr[0] <= raster_addr_in;
      for (int i = 1; i < PIPE_LAT; i++) begin
        sb_vld[i]  <= sb_vld[i-1];
        sb_addr[i] <= sb_addr[i-1];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fb_we_out      <= 1'b0;
      dp_we_out      <= 1'b0;
      dp_re_out      <= 1'b0;
      drawing_out    <= 1'b0;
      frame_done_out <= 1'b0;
      fb_front_out   <= 1'b0;
      fb_write_out   <= '0;
      dp_write_out   <= '0;
      fb_value_out   <= '0;
      dp_value_out   <= '0;
    end else begin
      fb_we_out      <= iss_we;
      dp_we_out      <= iss_we;
      dp_re_out      <= iss_re;
      drawing_out    <= iss_drawing;
      frame_done_out <= swap;
      if (swap) fb_front_out <= ~fb_front_out;
      if (iss_we) begin
        fb_write_out <= iss_addr;
        dp_write_out <= iss_addr;
        fb_value_out <= iss_fb;
        dp_value_out <= iss_dp;
      end
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed table-driven bench for frame_sequencer with a small framebuffer (8 pixels).
module tb_frame_sequencer;
  localparam logic [15:0] CC = 16'h00A5;
  localparam logic [15:0] CD = 16'hFFFF;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        frame_start_in, vsync_in, raster_valid_in, raster_done_in;
  logic        raster_ready_out;
  logic [16:0] raster_addr_in;
  logic [15:0] raster_color_in, raster_depth_in;
  logic        drawing_out, fb_we_out, dp_we_out, dp_re_out, fb_front_out;
  logic [16:0] fb_write_out, dp_write_out;
  logic [15:0] fb_value_out, dp_value_out;
  logic        busy_out, frame_done_out;

  always #5 clk_in = ~clk_in;

  frame_sequencer #(
    .FB_BIT_WIDTH(16), .DEPTH_BIT_WIDTH(16), .FB_ADDR_WIDTH(17), .FB_SIZE(8),
    .CLEAR_COLOR(CC), .CLEAR_DEPTH(CD), .PIPE_LAT(4)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_start_in(frame_start_in), .vsync_in(vsync_in),
    .raster_valid_in(raster_valid_in), .raster_ready_out(raster_ready_out),
    .raster_addr_in(raster_addr_in), .raster_color_in(raster_color_in),
    .raster_depth_in(raster_depth_in), .raster_done_in(raster_done_in),
    .drawing_out(drawing_out), .fb_we_out(fb_we_out), .dp_we_out(dp_we_out), .dp_re_out(dp_re_out),
    .fb_front_out(fb_front_out), .fb_write_out(fb_write_out), .dp_write_out(dp_write_out),
    .fb_value_out(fb_value_out), .dp_value_out(dp_value_out), .busy_out(busy_out),
    .frame_done_out(frame_done_out)
  );

  typedef struct {
    logic fs, vs, vld; logic [16:0] a; logic [15:0] c, d; logic done;
    logic rdy, we, re, drw; logic [16:0] wa; logic [15:0] fv, dv; logic busy, fd, front;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic fs, vs, vld, input logic [16:0] a, input logic [15:0] c, d,
                              input logic done, rdy, we, re, drw, input logic [16:0] wa,
                              input logic [15:0] fv, dv, input logic busy, fd, front);
    vec_t v;
    v.fs = fs; v.vs = vs; v.vld = vld; v.a = a; v.c = c; v.d = d; v.done = done;
    v.rdy = rdy; v.we = we; v.re = re; v.drw = drw; v.wa = wa; v.fv = fv; v.dv = dv;
    v.busy = busy; v.fd = fd; v.front = front;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic rdy, we, re, drw, input logic [16:0] wa,
                            input logic [15:0] fv, dv, input logic busy, fd, front);
    chk({tag, ".ready"},   raster_ready_out, rdy);
    chk({tag, ".fb_we"},   fb_we_out, we);
    chk({tag, ".dp_we"},   dp_we_out, we);
    chk({tag, ".dp_re"},   dp_re_out, re);
    chk({tag, ".drawing"}, drawing_out, drw);
    chk({tag, ".fb_addr"}, fb_write_out, wa);
    chk({tag, ".dp_addr"}, dp_write_out, wa);
    chk({tag, ".fb_val"},  fb_value_out, fv);
    chk({tag, ".dp_val"},  dp_value_out, dv);
    chk({tag, ".busy"},    busy_out, busy);
    chk({tag, ".fdone"},   frame_done_out, fd);
    chk({tag, ".front"},   fb_front_out, front);
  endtask

  task automatic idle_inputs();
    frame_start_in = 0; vsync_in = 0; raster_valid_in = 0; raster_done_in = 0;
    raster_addr_in = '0; raster_color_in = '0; raster_depth_in = '0;
  endtask

  initial begin
    int lat;
    // Frame 1: clear, ignored events, streaming, hazard stall, done with accept, drain, swap.
    tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 1,0,0));
    tbl.push_back(mk(0,0,1, 5,16'h9999,1,0, 0,1,0,0, 0,CC,CD, 1,0,0));
    for (int i = 3; i <= 9; i++)
      tbl.push_back(mk(0,0,(i < 5), 5,16'h9999,1,0, 0,1,0,0, 17'(i-2),CC,CD, 1,0,0));
    for (int i = 10; i <= 12; i++)
      tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 7,CC,CD, 1,0,0));
    tbl.push_back(mk(0,0,1, 10,16'h1111,16'h0100,0, 1,0,0,0, 7,CC,CD, 1,0,0));
    tbl.push_back(mk(0,0,1, 11,16'h2222,16'h0200,0, 1,1,1,1, 10,16'h1111,16'h0100, 1,0,0));
    tbl.push_back(mk(0,0,1, 12,16'h3333,16'h0300,0, 1,1,1,1, 11,16'h2222,16'h0200, 1,0,0));
    tbl.push_back(mk(1,0,1, 13,16'h4444,16'h0400,0, 1,1,1,1, 12,16'h3333,16'h0300, 1,0,0));
    tbl.push_back(mk(0,0,1, 20,16'h5555,16'h0500,0, 1,1,1,1, 13,16'h4444,16'h0400, 1,0,0));
    tbl.push_back(mk(0,0,1, 20,16'h6666,16'h0600,0, 0,1,1,1, 20,16'h5555,16'h0500, 1,0,0));
    for (int i = 19; i <= 21; i++)
      tbl.push_back(mk(0,0,1, 20,16'h6666,16'h0600,0, 0,0,0,1, 20,16'h5555,16'h0500, 1,0,0));
    tbl.push_back(mk(0,0,1, 20,16'h6666,16'h0600,0, 1,0,0,1, 20,16'h5555,16'h0500, 1,0,0));
    tbl.push_back(mk(0,0,1, 21,16'h7777,16'h0700,1, 1,1,1,1, 20,16'h6666,16'h0600, 1,0,0));
    tbl.push_back(mk(0,0,1, 30,16'h8888,16'h0800,1, 0,1,1,1, 21,16'h7777,16'h0700, 1,0,0));
    for (int i = 25; i <= 28; i++)
      tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,1, 21,16'h7777,16'h0700, 1,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 21,16'h7777,16'h0700, 1,0,0));
    tbl.push_back(mk(0,1,0, 0,0,0,0, 0,0,0,0, 21,16'h7777,16'h0700, 1,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 21,16'h7777,16'h0700, 0,1,1));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 21,16'h7777,16'h0700, 0,0,1));

    // Reset held three cycles with random inputs.
    rst_n_in = 1'b0;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_in); #1;
      frame_start_in  = 1'($urandom); vsync_in = 1'($urandom);
      raster_valid_in = 1'($urandom); raster_done_in = 1'($urandom);
      raster_addr_in  = 17'($urandom); raster_color_in = 16'($urandom); raster_depth_in = 16'($urandom);
      #1;
      check_outs($sformatf("rst%0d", k), 0,0,0,0, 0,0,0, 0,0,0);
    end
    @(posedge clk_in); #1;
    idle_inputs();
    rst_n_in = 1'b1;

    foreach (tbl[i]) begin
      frame_start_in  = tbl[i].fs;  vsync_in        = tbl[i].vs;
      raster_valid_in = tbl[i].vld; raster_addr_in  = tbl[i].a;
      raster_color_in = tbl[i].c;   raster_depth_in = tbl[i].d;
      raster_done_in  = tbl[i].done;
      #2;
      check_outs($sformatf("row%0d", i), tbl[i].rdy, tbl[i].we, tbl[i].re, tbl[i].drw, tbl[i].wa,
                 tbl[i].fv, tbl[i].dv, tbl[i].busy, tbl[i].fd, tbl[i].front);
      @(posedge clk_in); #1;
    end

    // Frame 2: every write carries fb_front_out=1; vsync already high when SWAP is entered.
    idle_inputs();
    frame_start_in = 1;
    @(posedge clk_in); #1;
    frame_start_in = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_in); #1;
      chk($sformatf("f2clr%0d.we", i), fb_we_out, 1);
      chk($sformatf("f2clr%0d.addr", i), fb_write_out, i);
      chk($sformatf("f2clr%0d.front", i), fb_front_out, 1);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in); #1;
      chk($sformatf("f2drain%0d.we", i), fb_we_out, 0);
    end
    raster_valid_in = 1; raster_addr_in = 17'd40; raster_color_in = 16'hBEEF;
    raster_depth_in = 16'h0042; raster_done_in = 1; vsync_in = 1;
    #1;
    chk("f2.ready", raster_ready_out, 1);
    @(posedge clk_in); #1;
    raster_valid_in = 0; raster_done_in = 0;
    chk("f2frag.we", fb_we_out, 1);
    chk("f2frag.re", dp_re_out, 1);
    chk("f2frag.addr", dp_write_out, 40);
    chk("f2frag.val", fb_value_out, 16'hBEEF);
    chk("f2frag.front", fb_front_out, 1);
    lat = -1;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(posedge clk_in); #1;
      if (frame_done_out) lat = k;
    end
    chk("f2.swap_latency", 32'(lat), 5);
    chk("f2.front_after", fb_front_out, 0);
    chk("f2.busy_after", busy_out, 0);
    vsync_in = 0;

    // Frame 3: asynchronous reset while the clear counter is at 5.
    frame_start_in = 1;
    @(posedge clk_in); #1;
    frame_start_in = 0;
    repeat (5) begin
      @(posedge clk_in); #1;
    end
    #1;
    chk("f3.pre_addr", fb_write_out, 4);
    chk("f3.pre_busy", busy_out, 1);
    raster_valid_in = 1; raster_addr_in = 17'd3;
    rst_n_in = 1'b0;
    #1;
    check_outs("async_rst", 0,0,0,0, 0,0,0, 0,0,0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_in); #1;
      chk($sformatf("post_rst%0d.we", k), fb_we_out, 0);
      chk($sformatf("post_rst%0d.busy", k), busy_out, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
